// File: rtl/trig_window_scheduler.sv
// -----------------------------------------------------------------------------
// trig_window_scheduler
//
// Arbitrates rising-edge trigger requests from NUM_CH channels. Each request
// produces one output window. The window is EXTEND_LEN cycles of SIG_OUT high
// (a value of 0 is treated as 1). It is followed by DEADTIME forced-low cycles,
// and then at least one idle cycle before the next grant. Arbitration is
// round-robin, starting after the channel that owned the last window.
// Each channel holds at most one pending request. A further edge on a channel
// that is already pending is dropped.
//
// Optional feature macro: TRIG_SCHED_DROP_CNT_EN
//   When this macro is defined, the DROP_CNT output is added. It is a 16-bit
//   saturating count of dropped edges.
//
// Ports
//   CLK         in   sole clock, rising edge
//   RESETN      in   asynchronous active-low reset
//   TRIG_IN     in   [NUM_CH]   per-channel trigger levels (rising edge = request)
//   EXTEND_LEN  in   [MAX_EXTEND_LEN_WIDTH] window length, sampled at grant
//   DEADTIME    in   [DEADTIME_WIDTH] low gap after a window, sampled on DEAD entry
//   SIG_OUT     out  registered window output
//   CH_SEL      out  [clog2(NUM_CH)] channel owning the current/last window
//   BUSY        out  registered, high while ACTIVE or DEAD
//   PENDING     out  [NUM_CH] registered pending-request bits
//   DROP_CNT    out  [16] dropped-edge count (only with TRIG_SCHED_DROP_CNT_EN)
// -----------------------------------------------------------------------------
module trig_window_scheduler #(
    parameter int NUM_CH               = 4,
    parameter int MAX_EXTEND_LEN_WIDTH = 5,
    parameter int DEADTIME_WIDTH       = 4
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic [NUM_CH-1:0]               TRIG_IN,
    input  logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
    input  logic [DEADTIME_WIDTH-1:0]       DEADTIME,
    output logic                            SIG_OUT,
    output logic [$clog2(NUM_CH)-1:0]       CH_SEL,
    output logic                            BUSY,
    output logic [NUM_CH-1:0]               PENDING
`ifdef TRIG_SCHED_DROP_CNT_EN
    ,
    output logic [15:0]                     DROP_CNT
`endif
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic [MAX_EXTEND_LEN_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic [DEADTIME_WIDTH-1:0]       dead_cnt_q, dead_cnt_d;
    logic                            sig_out_q, sig_out_d;
    logic                            busy_q, busy_d;
    logic [CW-1:0]                   ch_sel_q, ch_sel_d;
    logic [NUM_CH-1:0]               pending_q, pending_d;
    logic [NUM_CH-1:0]               trig_dly_q, trig_dly_d;

    logic [NUM_CH-1:0]               edge_s;
    logic [NUM_CH-1:0]               grant_s;
    logic [NUM_CH-1:0]               rot_s;
    logic [MAX_EXTEND_LEN_WIDTH-1:0] len_eff_s;
    logic [CW-1:0]                   rr_idx_s;
    int                              start_v;
    int                              off_v;
    int                              sum_v;

    // Edge detection against the delayed trigger copy, and zero-length window clamp.
    always_comb begin
        trig_dly_d = TRIG_IN;
        edge_s     = TRIG_IN & ~trig_dly_q;
        if (EXTEND_LEN == {MAX_EXTEND_LEN_WIDTH{1'b0}}) begin
            len_eff_s = MAX_EXTEND_LEN_WIDTH'(1'b1);
        end else begin
            len_eff_s = EXTEND_LEN;
        end
    end

    // Round-robin pick. The pending vector is rotated so that the channel after
    // the last owner sits at bit 0. The lowest set bit of the rotated vector is
    // then mapped back to a channel index.
    always_comb begin
        start_v = (int'(ch_sel_q) + 1) % NUM_CH;
        rot_s   = NUM_CH'({pending_q, pending_q} >> start_v);
        off_v   = 0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot_s[j]) begin
                off_v = j;
            end else begin
                off_v = off_v;
            end
        end
        sum_v = start_v + off_v;
        if (sum_v >= NUM_CH) begin
            sum_v = sum_v - NUM_CH;
        end else begin
            sum_v = sum_v;
        end
        rr_idx_s = CW'(sum_v);
    end

    // Window sequencer next-state logic: IDLE -> ACTIVE -> (DEAD) -> IDLE.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        dead_cnt_d = dead_cnt_q;
        sig_out_d  = sig_out_q;
        ch_sel_d   = ch_sel_q;
        grant_s    = {NUM_CH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_s[rr_idx_s] = 1'b1;
                    ch_sel_d          = rr_idx_s;
                    win_cnt_d         = len_eff_s;
                    sig_out_d         = 1'b1;
                    state_d           = ST_ACTIVE;
                end else begin
                    sig_out_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                // The counter holds the number of high cycles left, including this one.
                if (win_cnt_q <= MAX_EXTEND_LEN_WIDTH'(1'b1)) begin
                    sig_out_d = 1'b0;
                    win_cnt_d = {MAX_EXTEND_LEN_WIDTH{1'b0}};
                    if (DEADTIME != {DEADTIME_WIDTH{1'b0}}) begin
                        dead_cnt_d = DEADTIME;
                        state_d    = ST_DEAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    win_cnt_d = win_cnt_q - MAX_EXTEND_LEN_WIDTH'(1'b1);
                    sig_out_d = 1'b1;
                end
            end
            ST_DEAD: begin
                sig_out_d = 1'b0;
                if (dead_cnt_q <= DEADTIME_WIDTH'(1'b1)) begin
                    dead_cnt_d = {DEADTIME_WIDTH{1'b0}};
                    state_d    = ST_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEADTIME_WIDTH'(1'b1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sig_out_d  = 1'b0;
                win_cnt_d  = {MAX_EXTEND_LEN_WIDTH{1'b0}};
                dead_cnt_d = {DEADTIME_WIDTH{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        // A new edge wins over a same-cycle grant clear, so the bit stays set.
        pending_d = (pending_q & ~grant_s) | edge_s;
    end

    // State, counter and output registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= {MAX_EXTEND_LEN_WIDTH{1'b0}};
            dead_cnt_q <= {DEADTIME_WIDTH{1'b0}};
            sig_out_q  <= 1'b0;
            busy_q     <= 1'b0;
            ch_sel_q   <= CW'(NUM_CH - 1);
            pending_q  <= {NUM_CH{1'b0}};
            trig_dly_q <= {NUM_CH{1'b0}};
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            sig_out_q  <= sig_out_d;
            busy_q     <= busy_d;
            ch_sel_q   <= ch_sel_d;
            pending_q  <= pending_d;
            trig_dly_q <= trig_dly_d;
        end
    end

    assign SIG_OUT = sig_out_q;
    assign BUSY    = busy_q;
    assign CH_SEL  = ch_sel_q;
    assign PENDING = pending_q;

`ifdef TRIG_SCHED_DROP_CNT_EN
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [16:0]       drop_sum_s;
    logic [NUM_CH-1:0] drop_s;

    function automatic logic [16:0] count_ones(input logic [NUM_CH-1:0] v);
        logic [16:0] c;
        c = 17'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + {16'd0, v[i]};
        end
        return c;
    endfunction

    // Count dropped edges: the edge arrives while the channel is already pending
    // and the channel is not being granted in the same cycle.
    always_comb begin
        drop_s     = edge_s & pending_q & ~grant_s;
        drop_sum_s = {1'b0, drop_cnt_q} + count_ones(drop_s);
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
    end

    // Dropped-edge counter register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_trig_window_scheduler.sv
module tb_trig_window_scheduler;

    localparam int NCH = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] trig_in;
    logic [4:0] ext_len;
    logic [3:0] dead_t;
    logic       sig_out;
    logic [1:0] ch_sel;
    logic       busy;
    logic [3:0] pending;
`ifdef TRIG_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    trig_window_scheduler #(
        .NUM_CH(4),
        .MAX_EXTEND_LEN_WIDTH(5),
        .DEADTIME_WIDTH(4)
    ) dut (
        .CLK(clk),
        .RESETN(rst_n),
        .TRIG_IN(trig_in),
        .EXTEND_LEN(ext_len),
        .DEADTIME(dead_t),
        .SIG_OUT(sig_out),
        .CH_SEL(ch_sel),
        .BUSY(busy),
        .PENDING(pending)
`ifdef TRIG_SCHED_DROP_CNT_EN
        ,
        .DROP_CNT(drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model: timestamps of window boundaries -------
    logic [3:0] m_pend, m_trig_prev;
    int         m_chsel, m_wend, m_idle_at, m_n, m_drop;
    bit         m_in_win;
    logic       e_sig, e_busy;

    task automatic model_reset();
        m_pend      = 4'b0000;
        m_trig_prev = 4'b0000;
        m_chsel     = NCH - 1;
        m_in_win    = 1'b0;
        m_wend      = 0;
        m_idle_at   = m_n;
        m_drop      = 0;
        e_sig       = 1'b0;
        e_busy      = 1'b0;
    endtask

    // Model one rising edge. The edge index m_n is the timeline. A window
    // granted at edge g ends at edge g+L. The scheduler may grant again at
    // edge g+L+D+1.
    task automatic model_step();
        logic [3:0] edges, grant;
        bit found;
        int c;
        if (!rst_n) begin
            model_reset();
        end else begin
            edges = trig_in & ~m_trig_prev;
            grant = 4'b0000;
            if (m_in_win && m_n == m_wend) begin
                m_in_win  = 1'b0;
                m_idle_at = m_n + int'(dead_t) + 1;
            end
            if (!m_in_win && m_n >= m_idle_at && m_pend != 4'b0000) begin
                found = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_chsel + k) % NCH;
                    if (!found && m_pend[c]) begin
                        found    = 1'b1;
                        grant[c] = 1'b1;
                        m_chsel  = c;
                    end
                end
                m_wend   = m_n + ((ext_len == 5'd0) ? 1 : int'(ext_len));
                m_in_win = 1'b1;
            end
            for (int i = 0; i < NCH; i++) begin
                if (edges[i] && m_pend[i] && !grant[i] && m_drop < 65535) m_drop++;
            end
            m_pend      = (m_pend & ~grant) | edges;
            m_trig_prev = trig_in;
            e_sig       = m_in_win;
            e_busy      = m_in_win || (m_n < m_idle_at - 1);
        end
        m_n++;
    endtask

    task automatic compare_model();
        chk("model_sig_out", {31'd0, sig_out}, {31'd0, e_sig});
        chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
        chk("model_ch_sel", {30'd0, ch_sel}, m_chsel);
        chk("model_pending", {28'd0, pending}, {28'd0, m_pend});
`ifdef TRIG_SCHED_DROP_CNT_EN
        chk("model_drop_cnt", {16'd0, drop_cnt}, m_drop);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        trig_in = 4'b0000;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_rise(input int budget, output int lows, output bit ok);
        lows = 0;
        ok   = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sig_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            lows++;
            cyc();
        end
    endtask

    task automatic count_high(output int len);
        len = 0;
        for (int i = 0; i < 64; i++) begin
            if (sig_out !== 1'b1) break;
            len++;
            cyc();
        end
    endtask

    typedef struct {
        logic [3:0] trig;
        logic       exp_sig;
        logic       exp_busy;
        logic [1:0] exp_ch;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int  lows, len;
        bit  ok;
        int  ch_order[3];

        rst_n   = 1'b0;
        trig_in = 4'b0000;
        ext_len = 5'd4;
        dead_t  = 4'd2;
        m_n     = 0;
        model_reset();

        // Table: one edge on ch1, EXTEND_LEN=4, DEADTIME=2.
        tbl[0] = '{4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000};
        tbl[1] = '{4'b0010, 1'b0, 1'b0, 2'd3, 4'b0010};
        tbl[2] = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[3] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[4] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[5] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000};
        tbl[6] = '{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[7] = '{4'b0000, 1'b0, 1'b1, 2'd1, 4'b0000};
        tbl[8] = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000};
        tbl[9] = '{4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000};

        do_reset();
        chk("reset_sig_out", {31'd0, sig_out}, 32'd0);
        chk("reset_ch_sel", {30'd0, ch_sel}, 32'd3);
        chk("reset_pending", {28'd0, pending}, 32'd0);
        for (int r = 0; r < 10; r++) begin
            trig_in = tbl[r].trig;
            cyc();
            chk($sformatf("tbl%0d_sig", r), {31'd0, sig_out}, {31'd0, tbl[r].exp_sig});
            chk($sformatf("tbl%0d_busy", r), {31'd0, busy}, {31'd0, tbl[r].exp_busy});
            chk($sformatf("tbl%0d_ch", r), {30'd0, ch_sel}, {30'd0, tbl[r].exp_ch});
            chk($sformatf("tbl%0d_pend", r), {28'd0, pending}, {28'd0, tbl[r].exp_pend});
        end

        // Simultaneous edges on ch0, ch2 and ch3 with DEADTIME=0.
        do_reset();
        ext_len = 5'd2;
        dead_t  = 4'd0;
        trig_in = 4'b1101;
        cyc();
        trig_in = 4'b0000;
        for (int w = 0; w < 3; w++) begin
            wait_rise(20, lows, ok);
            chk($sformatf("rr_rise%0d", w), {31'd0, ok}, 32'd1);
            if (w > 0) chk($sformatf("rr_gap%0d", w), lows, 32'd1);
            ch_order[w] = int'(ch_sel);
            count_high(len);
            chk($sformatf("rr_len%0d", w), len, 32'd2);
        end
        chk("rr_order0", ch_order[0], 32'd0);
        chk("rr_order1", ch_order[1], 32'd2);
        chk("rr_order2", ch_order[2], 32'd3);

        // EXTEND_LEN=0 gives a 1-cycle window. A mid-window change from 3 to 8
        // affects only the next window.
        do_reset();
        ext_len = 5'd0;
        trig_in = 4'b0010;
        cyc();
        trig_in = 4'b0000;
        wait_rise(10, lows, ok);
        chk("len0_rise", {31'd0, ok}, 32'd1);
        count_high(len);
        chk("len0_len", len, 32'd1);
        ext_len = 5'd3;
        trig_in = 4'b0110;
        cyc();
        trig_in = 4'b0000;
        wait_rise(10, lows, ok);
        chk("len3_rise", {31'd0, ok}, 32'd1);
        ext_len = 5'd8;
        count_high(len);
        chk("len3_len", len, 32'd3);
        wait_rise(10, lows, ok);
        chk("len8_rise", {31'd0, ok}, 32'd1);
        count_high(len);
        chk("len8_len", len, 32'd8);

        // Three edges on ch2 during a ch0 window give one ch2 window.
        do_reset();
        ext_len = 5'd12;
        trig_in = 4'b0001;
        cyc();
        trig_in = 4'b0000;
        wait_rise(10, lows, ok);
        chk("drop_rise0", {31'd0, ok}, 32'd1);
        for (int p = 0; p < 3; p++) begin
            trig_in = 4'b0100;
            cyc();
            trig_in = 4'b0000;
            cyc();
        end
        chk("drop_pending", {28'd0, pending}, 32'h4);
        count_high(len);
        wait_rise(10, lows, ok);
        chk("drop_rise1", {31'd0, ok}, 32'd1);
        chk("drop_ch2", {30'd0, ch_sel}, 32'd2);
        count_high(len);
        chk("drop_len", len, 32'd12);
        wait_rise(30, lows, ok);
        chk("drop_no_extra", {31'd0, ok}, 32'd0);
`ifdef TRIG_SCHED_DROP_CNT_EN
        chk("drop_cnt", {16'd0, drop_cnt}, 32'd2);
`endif

        // Asynchronous reset in cycle 2 of a 10-cycle window.
        ext_len = 5'd10;
        trig_in = 4'b0110;
        cyc();
        trig_in = 4'b0000;
        wait_rise(10, lows, ok);
        chk("arst_rise0", {31'd0, ok}, 32'd1);
        cyc();
        #2;
        rst_n   = 1'b0;
        trig_in = 4'b0001;
        #1;
        chk("arst_sig_out", {31'd0, sig_out}, 32'd0);
        chk("arst_pending", {28'd0, pending}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ch_sel", {30'd0, ch_sel}, 32'd3);
        model_reset();
        #2;
        rst_n = 1'b1;
        wait_rise(10, lows, ok);
        chk("arst_rise1", {31'd0, ok}, 32'd1);
        chk("arst_rise_lat", lows, 32'd2);
        chk("arst_ch0", {30'd0, ch_sel}, 32'd0);
        trig_in = 4'b0000;
        count_high(len);
        chk("arst_len", len, 32'd10);

        // Randomized traffic against the model, with mid-window parameter changes.
        do_reset();
        ext_len = 5'd3;
        dead_t  = 4'd1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) ext_len = 5'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) dead_t = 4'($urandom_range(0, 3));
            trig_in = trig_in ^ (4'($urandom) & 4'($urandom));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trig_window_scheduler.md
TRIG_WINDOW_SCHEDULER -- requirements
Module: trig_window_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of trigger requester channels, 2..16.
REQ-002 Parameter MAX_EXTEND_LEN_WIDTH, default 5: width of EXTEND_LEN and of the window counter.
REQ-003 Parameter DEADTIME_WIDTH, default 4: width of DEADTIME and of the dead-time counter.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RESETN  in  1  asynchronous, active-low reset.
REQ-006 TRIG_IN  in  NUM_CH  per-channel trigger level; a rising edge is a request.
REQ-007 EXTEND_LEN  in  MAX_EXTEND_LEN_WIDTH  output window length in cycles.
REQ-008 DEADTIME  in  DEADTIME_WIDTH  forced-low gap after each window, in cycles.
REQ-009 SIG_OUT  out  1  extended window, registered.
REQ-010 CH_SEL  out  clog2(NUM_CH)  index of channel owning the current/last window.
REQ-011 BUSY  out  1  high in ACTIVE or DEAD.
REQ-012 PENDING  out  NUM_CH  registered pending-request bits.

Function
REQ-013 Edge detect: registered copy trig_d of TRIG_IN; edge[i] = TRIG_IN[i] & ~trig_d[i] at each CLK edge.
REQ-014 An edge sets PENDING[i] at that CLK edge; grant clears it; set and clear in the same cycle -> bit stays set.
REQ-015 FSM states IDLE, ACTIVE, DEAD.
REQ-016 IDLE: if any PENDING bit set, grant by round-robin starting at channel (last CH_SEL + 1) mod NUM_CH, wrapping; load window counter; go ACTIVE; else stay IDLE.
REQ-017 Grant latches EXTEND_LEN and CH_SEL; changes to EXTEND_LEN/DEADTIME mid-window have no effect until the next grant / DEAD entry.
REQ-018 EXTEND_LEN = 0 is treated as 1.
REQ-019 ACTIVE: SIG_OUT high for exactly the latched length in cycles, then to DEAD if DEADTIME > 0, else IDLE.
REQ-020 DEAD: SIG_OUT low for exactly DEADTIME cycles (value latched on DEAD entry), then IDLE.
REQ-021 Latency: edge sampled at CLK edge k -> PENDING set at k -> SIG_OUT high from edge k+1 if FSM IDLE at k.
REQ-022 Back-to-back with DEADTIME = 0: SIG_OUT low for exactly 1 cycle (IDLE) between windows.
REQ-023 An edge on a channel whose PENDING bit is already set is dropped (no queuing beyond one per channel).
REQ-024 An edge on the currently granted channel during ACTIVE/DEAD sets its PENDING bit normally.

Reset
REQ-025 RESETN low asynchronously forces: state IDLE, SIG_OUT 0, BUSY 0, PENDING 0, trig_d 0, counters 0, CH_SEL NUM_CH-1 (so channel 0 wins the first arbitration).
REQ-026 Reset mid-window terminates it immediately; pending requests are discarded.
REQ-027 TRIG_IN held high across reset release is seen as an edge at the first CLK edge after release.

Configuration
REQ-028 Macro TRIG_SCHED_DROP_CNT_EN defined: adds output DROP_CNT (16 bits), incremented per dropped edge per REQ-023 (multiple channels same cycle add their count), saturating at 0xFFFF, reset to 0.
REQ-029 Macro undefined: no DROP_CNT port and no counter logic; all other behaviour identical.

Verification
REQ-030 EXTEND_LEN=4, DEADTIME=2, one edge on ch1 -> SIG_OUT high 4 cycles starting 1 cycle after edge, CH_SEL=1, BUSY high 6 cycles.
REQ-031 Edges on ch0, ch2, ch3 in same cycle, DEADTIME=0 -> windows granted in order 0,2,3, each separated by exactly 1 low cycle.
REQ-032 EXTEND_LEN=0 -> 1-cycle window; EXTEND_LEN changed 3->8 mid-window -> current window stays 3, next is 8.
REQ-033 Three edges on ch2 while ch0 window active -> one ch2 window only; DROP_CNT=2 with TRIG_SCHED_DROP_CNT_EN.
REQ-034 RESETN low during cycle 2 of a 10-cycle window -> SIG_OUT 0 without waiting for CLK, PENDING 0; TRIG_IN high at release -> new window on channel 0.
